// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: FSM state encoding,
// next-PC select codes and the default address width.
package pc_pkg;

    localparam int PC_ADDR_W = 32;

    typedef logic [1:0] pc_state_t;

    localparam pc_state_t ST_BOOT = 2'd0;
    localparam pc_state_t ST_RUN  = 2'd1;
    localparam pc_state_t ST_HALT = 2'd2;

    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_HOLD,
        SEL_RET,
        SEL_JMP,
        SEL_BR,
        SEL_INC
    } pc_sel_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Ports: clk, rst_n, push, pop, din -> top, empty, full.
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PONE = PW'(1);
    localparam logic [PW:0]   CMAX = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW:0]   count;

    assign empty = (count == '0);
    assign full  = (count == CMAX);
    assign top   = mem[ptr - PONE];

    // ptr is the next write slot; it wraps freely because DEPTH is 2^n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PONE;
            if (!full)
                count <= count + 1'b1;
        end else if (pop && !empty) begin
            ptr   <= ptr - PONE;
            count <= count - 1'b1;
        end
    end

    // Storage survives reset; a zero count makes it unreachable.
    always_ff @(posedge clk) begin
        if (push)
            mem[ptr] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with BOOT/RUN/HALT sequencing and trap/jump/branch redirects.
// Ports: CLK, RSTn, Stall, Halt, Resume, Branch/BranchTarget, Jump/JumpTarget,
//   Call, Ret, Trap/TrapVec -> PCOut, PCp1, Halted, RasUnderflow.
// Define PC_RAS_EN to add the return-address stack (pc_ras).
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = PC_ADDR_W,
    parameter int                STEP      = 1,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Stall,
    input  logic              Halt,
    input  logic              Resume,
    input  logic              Branch,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpTarget,
    input  logic              Call,
    input  logic              Ret,
    input  logic              Trap,
    input  logic [ADDR_W-1:0] TrapVec,
    output logic [ADDR_W-1:0] PCOut,
    output logic [ADDR_W-1:0] PCp1,
    output logic              Halted,
    output logic              RasUnderflow
);

    pc_state_t         state;
    pc_state_t         state_nxt;
    pc_sel_t           sel;
    logic [ADDR_W-1:0] pc_nxt;
    logic              run;
    logic              ret_req;
    logic              ras_empty;
    logic [ADDR_W-1:0] ras_top;

    assign PCp1   = PCOut + ADDR_W'(STEP);
    assign Halted = (state == ST_HALT);
    assign run    = (state == ST_RUN);

`ifdef PC_RAS_EN
    logic ras_push;
    logic ras_pop;
    logic ras_full;
    logic unused_full;

    assign ret_req     = Ret;
    assign unused_full = ras_full;
    assign ras_push    = run && (sel == SEL_JMP) && Call;
    assign ras_pop     = run && (sel == SEL_RET) && !ras_empty;

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk   (CLK),
        .rst_n (RSTn),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (PCp1),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            RasUnderflow <= 1'b0;
        else if (run && (sel == SEL_RET) && ras_empty)
            RasUnderflow <= 1'b1;
    end
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_ret;

    assign unused_ret   = Ret;
    assign ret_req      = 1'b0;
    assign ras_empty    = 1'b1;
    assign ras_top      = '0;
    assign RasUnderflow = 1'b0;
`endif

    // Priority order of redirect sources while running.
    always_comb begin
        sel = SEL_INC;
        if (Trap)
            sel = SEL_TRAP;
        else if (Stall)
            sel = SEL_HOLD;
        else if (ret_req)
            sel = SEL_RET;
        else if (Call || Jump)
            sel = SEL_JMP;
        else if (Branch)
            sel = SEL_BR;
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = PCOut;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN: begin
                if (!Trap && Halt)
                    state_nxt = ST_HALT;
                case (sel)
                    SEL_TRAP: pc_nxt = TrapVec;
                    SEL_HOLD: pc_nxt = PCOut;
                    // Ret on an empty stack falls through to the increment.
                    SEL_RET:  pc_nxt = ras_empty ? PCp1 : ras_top;
                    SEL_JMP:  pc_nxt = JumpTarget;
                    SEL_BR:   pc_nxt = BranchTarget;
                    default:  pc_nxt = PCp1;
                endcase
            end
            ST_HALT: begin
                if (Trap) begin
                    pc_nxt    = TrapVec;
                    state_nxt = ST_RUN;
                end else if (Resume) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
                pc_nxt    = RESET_VEC;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_BOOT;
            PCOut <= RESET_VEC;
        end else begin
            state <= state_nxt;
            PCOut <= pc_nxt;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a queue-based reference model checked
// every cycle, plus literal PC expectations at key points of the sequence.
module tb_pc_sequencer;

`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        Stall = 1'b0, Halt = 1'b0, Resume = 1'b0;
    logic        Branch = 1'b0, Jump = 1'b0, Call = 1'b0;
    logic        Ret = 1'b0, Trap = 1'b0;
    logic [31:0] BranchTarget = '0, JumpTarget = '0, TrapVec = '0;
    logic [31:0] PCOut, PCp1;
    logic        Halted, RasUnderflow;
    logic [7:0]  pc8, pcp1_8;
    logic        halted8, uf8;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    pc_sequencer #(
        .ADDR_W(32), .STEP(1), .RESET_VEC(32'h100), .RAS_DEPTH(4)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .Stall(Stall), .Halt(Halt),
        .Resume(Resume), .Branch(Branch), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget), .Call(Call), .Ret(Ret),
        .Trap(Trap), .TrapVec(TrapVec), .PCOut(PCOut), .PCp1(PCp1),
        .Halted(Halted), .RasUnderflow(RasUnderflow)
    );

    pc_sequencer #(
        .ADDR_W(8), .STEP(4), .RESET_VEC(8'hF8), .RAS_DEPTH(4)
    ) dut8 (
        .CLK(CLK), .RSTn(RSTn), .Stall(1'b0), .Halt(1'b0),
        .Resume(1'b0), .Branch(1'b0), .BranchTarget(8'h00),
        .Jump(1'b0), .JumpTarget(8'h00), .Call(1'b0), .Ret(1'b0),
        .Trap(1'b0), .TrapVec(8'h00), .PCOut(pc8), .PCp1(pcp1_8),
        .Halted(halted8), .RasUnderflow(uf8)
    );

    // Reference model state.
    logic [31:0] m_pc = 32'h100;
    logic        m_boot = 1'b1;
    logic        m_halt = 1'b0;
    logic        m_uf = 1'b0;
    logic [31:0] m_ras[$];
    logic [7:0]  m8 = 8'hF8;
    logic        m8_boot = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always begin
        @(posedge CLK or negedge RSTn);
        if (!RSTn) begin
            m_pc = 32'h100; m_boot = 1'b1; m_halt = 1'b0; m_uf = 1'b0;
            m_ras.delete();
            m8 = 8'hF8; m8_boot = 1'b1;
        end else begin
            if (m8_boot) m8_boot = 1'b0;
            else m8 = m8 + 8'd4;
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (m_halt) begin
                if (Trap) begin m_pc = TrapVec; m_halt = 1'b0; end
                else if (Resume) m_halt = 1'b0;
            end else if (Trap) begin
                m_pc = TrapVec;
            end else begin
                if (Halt) m_halt = 1'b1;
                if (Stall) begin
                end else if (RAS_ON && Ret) begin
                    if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                    else begin m_pc = m_pc + 1; m_uf = 1'b1; end
                end else if (Call || Jump) begin
                    if (RAS_ON && Call) begin
                        m_ras.push_back(m_pc + 1);
                        if (m_ras.size() > 4) void'(m_ras.pop_front());
                    end
                    m_pc = JumpTarget;
                end else if (Branch) begin
                    m_pc = BranchTarget;
                end else begin
                    m_pc = m_pc + 1;
                end
            end
        end
    end

    always begin
        @(negedge CLK);
        chk("pc", PCOut, m_pc);
        chk("pcp1", PCp1, m_pc + 32'd1);
        chk("halted", {31'b0, Halted}, {31'b0, m_halt});
        chk("ras_uf", {31'b0, RasUnderflow}, {31'b0, m_uf});
        chk("pc8", {24'b0, pc8}, {24'b0, m8});
        chk("pcp1_8", {24'b0, pcp1_8}, {24'b0, m8 + 8'd4});
        chk("flags8", {30'b0, halted8, uf8}, 32'd0);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clr();
        Stall = 0; Halt = 0; Resume = 0; Branch = 0; Jump = 0;
        Call = 0; Ret = 0; Trap = 0;
    endtask

    task automatic lit(input string nm, input logic [31:0] exp);
        chk(nm, PCOut, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        cyc(2);
        lit("reset_pc", 32'h100);
        RSTn = 1;
        cyc(1); lit("boot", 32'h100); chk("w8_f8", {24'b0, pc8}, 32'hF8);
        cyc(1); lit("inc1", 32'h101); chk("w8_fc", {24'b0, pc8}, 32'hFC);
        cyc(1); lit("inc2", 32'h102); chk("w8_00", {24'b0, pc8}, 32'h00);
        Branch = 1; BranchTarget = 32'h200; Jump = 1; JumpTarget = 32'h300;
        cyc(1); lit("jmp_over_br", 32'h300);
        chk("w8_04", {24'b0, pc8}, 32'h04);
        clr(); Stall = 1; Branch = 1;
        cyc(1); lit("stall_br", 32'h300);
        Trap = 1; TrapVec = 32'h10;
        cyc(1); lit("stall_trap", 32'h10);
        clr(); Jump = 1; JumpTarget = 32'h120;
        cyc(1); lit("to_120", 32'h120);
        clr(); Halt = 1;
        cyc(1); lit("halt_adv", 32'h121);
        chk("halted_lit", {31'b0, Halted}, 32'd1);
        clr();
        cyc(2); lit("halt_hold", 32'h121);
        Resume = 1;
        cyc(1); lit("resume_hold", 32'h121);
        clr();
        cyc(1); lit("resume_inc", 32'h122);
        Halt = 1;
        cyc(1); lit("halt2", 32'h123);
        clr(); Trap = 1; TrapVec = 32'h40;
        cyc(1); lit("halt_trap", 32'h40);
        chk("trap_run", {31'b0, Halted}, 32'd0);
        clr();
        cyc(1); lit("after_trap", 32'h41);
        Halt = 1; Trap = 1; TrapVec = 32'h50;
        cyc(1); lit("halt_trap_run", 32'h50);
        clr();
        cyc(1); lit("ht_inc", 32'h51);
        Stall = 1; Halt = 1;
        cyc(1); lit("stall_halt", 32'h51);
        clr(); Resume = 1;
        cyc(1); clr();
        cyc(1); lit("resume2", 32'h52);
        // Call / Ret
        Jump = 1; JumpTarget = 32'h10;
        cyc(1); lit("to_10", 32'h10);
        clr(); Call = 1; JumpTarget = 32'h80;
        cyc(1); lit("call", 32'h80);
        clr();
        cyc(1); lit("in_callee", 32'h81);
        Ret = 1;
        cyc(1); lit("ret1", RAS_ON ? 32'h11 : 32'h82);
        clr();
        for (int i = 1; i <= 5; i++) begin
            Call = 1; JumpTarget = 32'(i) << 12;
            cyc(1);
        end
        clr(); Ret = 1;
        for (int i = 4; i >= 1; i--) begin
            cyc(1);
            lit("nest_ret", RAS_ON ? ((32'(i) << 12) + 32'd1)
                                   : (32'h5000 + 32'(5 - i)));
        end
        cyc(1); lit("ret5", RAS_ON ? 32'h1002 : 32'h5005);
        clr();
        cyc(2); lit("uf_sticky", RAS_ON ? 32'h1004 : 32'h5007);
        Call = 1; Ret = 1; JumpTarget = 32'h700;
        cyc(1); lit("call_ret", RAS_ON ? 32'h1005 : 32'h700);
        clr();
        cyc(1);
        // Asynchronous reset mid-cycle, with a jump held through BOOT.
        #2 RSTn = 0;
        cyc(1); lit("midrst", 32'h100);
        Jump = 1; JumpTarget = 32'h900;
        RSTn = 1;
        cyc(1); lit("boot_ignores", 32'h100);
        cyc(1); lit("boot_jmp", 32'h900);
        clr(); Ret = 1;
        cyc(1); lit("ret_empty", 32'h901);
        chk("uf_lit", {31'b0, RasUnderflow}, {31'b0, RAS_ON});
        clr();
        cyc(3);
        chk("uf_keep", {31'b0, RasUnderflow}, {31'b0, RAS_ON});
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
